sd_cmd_engine: RTL
==================

# sd_cmd_engine

Command-line engine for the SD host: accepts a command (index, argument, expected response type), builds and serialises the 48-bit command frame with CRC7 onto the CMD pad, then receives and checks the card's response. It sits directly upstream of the `sd_bus_master` pad logic. It is paced by the SD clock strobes from the bus master's clock divider, and it is driven by the card-init/read sequencer.

## Interface
- `RESP_TIMEOUT`, 64: number of SD clock rise strobes to wait for a response start bit (NCR limit).
- `GAP_CLKS`, 8: high-level SD clocks driven/waited after each transaction before `cmd_ready` returns (NRC/NCC).

Ports:
- `clk` in 1: system clock; the block's only clock.
- `reset` in 1: asynchronous, active-high.
- `sd_fall_stb` in 1: one-`clk` pulse at each SD clock falling edge; the only drive-update point.
- `sd_rise_stb` in 1: one-`clk` pulse at each SD clock rising edge; the only `cmd_in` sample point.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block idle, request accepted on `cmd_valid && cmd_ready`.
- `cmd_index` in 6: command index.
- `cmd_arg` in 32: command argument.
- `resp_type` in 2: encodings are 0 = none, 1 = 48-bit with CRC (R1/R6/R7), 2 = 136-bit (R2), 3 = 48-bit no CRC check (R3).
- `resp_valid` out 1: one-`clk` pulse when the transaction completes.
- `resp_data` out 128: received bits; see Operation.
- `resp_status` out 2: encodings are 0 = OK, 1 = CRC error, 2 = timeout, 3 = framing error (end bit 0).
- `cmd_out` out 1: CMD pad output value.
- `cmd_oe` out 1: CMD pad output enable.
- `cmd_in` in 1: CMD pad input (pulled up).

## Operation
- Frame on the line: `{0, 1, cmd_index, cmd_arg, crc7, 1}`, sent MSB first. `crc7` is polynomial x^7+x^3+1 over the first 40 bits, initial value 0.
- Inputs are latched on acceptance; later input changes are ignored.
- State `IDLE`: `cmd_ready`=1, `cmd_oe`=0, `cmd_out`=1.
- State `TX`: on each `sd_fall_stb`, drive the next frame bit with `cmd_oe`=1. The CRC is computed serially while bits 47..8 are driven, then shifted out as bits 7..1.
- On the `sd_fall_stb` after the end bit: `cmd_oe`=0, `cmd_out`=1.
  - If `resp_type`=0, go to `GAP`.
  - Otherwise go to `WAIT_START`.
- State `WAIT_START`: sample on `sd_rise_stb`.
  - `cmd_in`=0 is the start bit; go to `RX`.
  - After `RESP_TIMEOUT` rise strobes with no start bit, set status 2 and go to `GAP`.
- State `RX`: shift in the remaining 47 bits (48-bit response) or 135 bits (136-bit response) on rise strobes. The end bit is the last sample.
- `resp_data` for 48-bit responses:
  - `resp_data[37:0]` = frame bits 45:8 (index + 32-bit payload).
  - `resp_data[127:38]` = 0.
- `resp_data` for 136-bit responses: `resp_data[127:0]` = frame bits 127:0 (CID/CSD including its internal CRC and end bit).
- CRC check:
  - Type 1: over frame bits 47:8, compared against bits 7:1.
  - Type 2: over bits 127:8, compared against bits 7:1.
  - Type 3: no check.
- Status precedence: framing (3) > CRC (1) > OK (0).
- State `GAP`:
  - `resp_valid` pulses with the final `resp_status` and `resp_data`.
  - The CMD line stays released for `GAP_CLKS` fall strobes.
  - Then go to `IDLE`.
- `resp_data` and `resp_status` hold their values until the next `resp_valid`.

## Timing
- Reset values: `cmd_ready`=1, `cmd_oe`=0, `cmd_out`=1, `resp_valid`=0, `resp_data`=0, `resp_status`=0, state `IDLE`. An in-flight transaction is aborted and no `resp_valid` is issued.
- `cmd_ready` falls the `clk` cycle after acceptance.
- The start bit appears at the first `sd_fall_stb` strictly after acceptance. A strobe in the acceptance cycle itself does not count.
- `cmd_oe` is high for exactly 48 SD clocks.
- `resp_valid` is registered: it is asserted in the `clk` cycle after the `sd_rise_stb` that samples the end bit or ends the timeout. With type 0, it is asserted the cycle after `cmd_oe` falls.
- The timeout count starts at the first rise strobe after `cmd_oe` falls. Rise strobes at or before the end-bit fall strobe are ignored.
- `sd_fall_stb` and `sd_rise_stb` never coincide (divider guarantee). The bench asserts this.
- `cmd_valid` while not ready is ignored and not queued.

## Structure
- Package `sd_pkg` holds:
  - `resp_type` and `resp_status` encodings;
  - the state enum;
  - the frame length constants (48, 136).
- Sub-module `sd_crc7` is a serial CRC7 with `clear`, `en`, `din`, and `crc[6:0]`. It is shared by TX and RX, since they never overlap.
- Counters: a bit counter (8 bits, max 135) and a timeout/gap counter sized by `$clog2(RESP_TIMEOUT+1)`.

## Test plan
- CMD0, arg 0, type 0 → line shows `0x40 00 00 00 00 95` MSB first; `resp_valid` with status 0; `cmd_ready` returns after 8 gap clocks.
- CMD8, arg 0x1AA, type 1; bench card replies `0x08 00 00 01 AA 13` after 5 SD clocks → frame sent `0x48 00 00 01 AA 87`; `resp_data` = `0x08000001AA`; status 0.
- Same as the CMD8 case with one flipped response payload bit → status 1; with end bit forced 0 → status 3.
- CMD17, type 1, card silent → status 2 exactly 64 rise strobes after `cmd_oe` falls; `resp_data` unchanged.
- CMD2, type 2, 136-bit CID reply with valid internal CRC → `resp_data` equals CID bits 127:0; status 0; type 3 reply with a bad CRC → status 0.
- `reset` asserted mid-`TX` and mid-`RX` → `cmd_oe`=0, `cmd_out`=1, `cmd_ready`=1 immediately; no `resp_valid`; the next command runs normally.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared encodings, FSM states and frame lengths for the SD command engine.
package sd_pkg;
   typedef enum logic [1:0] {RT_NONE = 2'd0, RT_R1 = 2'd1, RT_R2 = 2'd2, RT_R3 = 2'd3} resp_type_e;
   typedef enum logic [1:0] {RS_OK = 2'd0, RS_CRC = 2'd1, RS_TIMEOUT = 2'd2, RS_FRAME = 2'd3} resp_status_e;
   typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT_START, S_RX, S_RESP, S_GAP} state_e;
   localparam int unsigned FRAME_SHORT = 48;
   localparam int unsigned FRAME_LONG  = 136;
endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, zero initial value.
module sd_crc7 (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);
   logic [6:0] crc_q;
   logic       fb;

   assign fb  = din ^ crc_q[6];
   assign crc = crc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      crc_q <= '0;
      else if (clear) crc_q <= '0;
      else if (en)    crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   end
endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD line engine: serialises command frame + CRC7, receives and checks the response.
module sd_cmd_engine
   import sd_pkg::*;
#(
   parameter int RESP_TIMEOUT = 64,
   parameter int GAP_CLKS     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sd_fall_stb,
   input  logic         sd_rise_stb,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   resp_type,
   output logic         resp_valid,
   output logic [127:0] resp_data,
   output logic [1:0]   resp_status,
   output logic         cmd_out,
   output logic         cmd_oe,
   input  logic         cmd_in
);
   localparam int TW = $clog2(RESP_TIMEOUT + 1);

   state_e        state_q, state_d;
   resp_type_e    type_q, type_d;
   logic [7:0]    bcnt_q, bcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [39:0]   sh_q, sh_d;
   logic [126:0]  rx_q, rx_d;
   logic          oe_q, oe_d, out_q, out_d, rvld_q, rvld_d;
   logic [127:0]  rdata_q, rdata_d;
   logic [1:0]    rstat_q, rstat_d;
   logic          crc_clr, crc_en, crc_din;
   logic [6:0]    crc;
   logic [127:0]  rx_frame;
   logic [7:0]    rx_pos, crc_hi;
   logic [2:0]    tx_idx;

   // rx_pos is the frame bit number of the sample currently on cmd_in
   assign rx_frame = {rx_q, cmd_in};
   assign rx_pos   = ((type_q == RT_R2) ? 8'(FRAME_LONG) : 8'(FRAME_SHORT)) - 8'd1 - bcnt_q;
   assign crc_hi   = (type_q == RT_R2) ? 8'd127 : 8'd47;
   assign tx_idx   = 3'd6 - bcnt_q[2:0];

   assign cmd_ready   = (state_q == S_IDLE);
   assign cmd_oe      = oe_q;
   assign cmd_out     = out_q;
   assign resp_valid  = rvld_q;
   assign resp_data   = rdata_q;
   assign resp_status = rstat_q;

   sd_crc7 u_crc (
      .clk   (clk),
      .reset (reset),
      .clear (crc_clr),
      .en    (crc_en),
      .din   (crc_din),
      .crc   (crc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         type_q  <= RT_NONE;
         bcnt_q  <= '0;
         tcnt_q  <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
         oe_q    <= 1'b0;
         out_q   <= 1'b1;
         rvld_q  <= 1'b0;
         rdata_q <= '0;
         rstat_q <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         bcnt_q  <= bcnt_d;
         tcnt_q  <= tcnt_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         oe_q    <= oe_d;
         out_q   <= out_d;
         rvld_q  <= rvld_d;
         rdata_q <= rdata_d;
         rstat_q <= rstat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      bcnt_d  = bcnt_q;
      tcnt_d  = tcnt_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      oe_d    = oe_q;
      out_d   = out_q;
      rvld_d  = 1'b0;
      rdata_d = rdata_q;
      rstat_d = rstat_q;
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      crc_din = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            sh_d    = {2'b01, cmd_index, cmd_arg};
            type_d  = resp_type_e'(resp_type);
            bcnt_d  = '0;
            crc_clr = 1'b1;
            state_d = S_TX;
         end
         S_TX: if (sd_fall_stb) begin
            if (bcnt_q == 8'd48) begin
               oe_d    = 1'b0;
               out_d   = 1'b1;
               tcnt_d  = '0;
               crc_clr = 1'b1;
               state_d = (type_q == RT_NONE) ? S_RESP : S_WAIT_START;
            end else begin
               oe_d   = 1'b1;
               bcnt_d = bcnt_q + 8'd1;
               if (bcnt_q < 8'd40) begin
                  out_d   = sh_q[39];
                  sh_d    = {sh_q[38:0], 1'b0};
                  crc_en  = 1'b1;
                  crc_din = sh_q[39];
               end else if (bcnt_q < 8'd47) begin
                  out_d = crc[tx_idx];
               end else begin
                  out_d = 1'b1;
               end
            end
         end
         S_WAIT_START: if (sd_rise_stb) begin
            if (!cmd_in) begin
               state_d = S_RX;
               bcnt_d  = 8'd1;
               rx_d    = '0;
               crc_en  = (type_q != RT_R2);
            end else if (tcnt_q == TW'(RESP_TIMEOUT - 1)) begin
               rvld_d  = 1'b1;
               rstat_d = RS_TIMEOUT;
               tcnt_d  = '0;
               state_d = S_GAP;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         S_RX: if (sd_rise_stb) begin
            rx_d   = rx_frame[126:0];
            bcnt_d = bcnt_q + 8'd1;
            if (rx_pos >= 8'd8 && rx_pos <= crc_hi) begin
               crc_en  = 1'b1;
               crc_din = cmd_in;
            end
            if (rx_pos == 8'd0) begin
               rvld_d  = 1'b1;
               tcnt_d  = '0;
               state_d = S_GAP;
               rdata_d = (type_q == RT_R2) ? rx_frame : {90'd0, rx_frame[45:8]};
               if (!cmd_in)                                        rstat_d = RS_FRAME;
               else if (type_q != RT_R3 && rx_frame[7:1] != crc)   rstat_d = RS_CRC;
               else                                                rstat_d = RS_OK;
            end
         end
         S_RESP: begin
            rvld_d  = 1'b1;
            rstat_d = RS_OK;
            tcnt_d  = '0;
            state_d = S_GAP;
         end
         S_GAP: if (sd_fall_stb) begin
            if (tcnt_q == TW'(GAP_CLKS - 1)) state_d = S_IDLE;
            else                             tcnt_d  = tcnt_q + TW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule
